// File: rtl/if_id_pkg.sv
// Shared types for the IF->ID pipeline register: FSM states, default NOP encoding, entry layout.
package if_id_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } if_id_state_e;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } if_id_entry_t;

endpackage

// File: rtl/if_id_slot.sv
// One storage slot: data register written only on load, valid bit set by load and cleared by clear/reset.
// 1-cycle write latency; no backpressure of its own.
module if_id_slot #(
    parameter int W = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic         vld_o,
    output logic [W-1:0] q_o
);

    logic         vld_q;
    logic [W-1:0] dat_q;

    always_ff @(posedge clock) begin
        if (reset || clear_i) begin
            vld_q <= 1'b0;
        end else if (load_i) begin
            vld_q <= 1'b1;
        end
    end

    // Data has no reset: the valid bit alone decides whether it is shown.
    always_ff @(posedge clock) begin
        if (load_i) begin
            dat_q <= d_i;
        end
    end

    assign vld_o = vld_q;
    assign q_o   = dat_q;

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF->ID register with main+skid slots, flush and NOP bubbles; entry visible 1 cycle after push.
// in_ready is registered and drops only when both slots hold data; IF_ID_STATS_EN adds stall/bubble counters.
module if_id_pipe_reg
    import if_id_pkg::*;
#(
    parameter int                 INSTR_W   = 32,
    parameter int                 PC_W      = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT)
`ifdef IF_ID_STATS_EN
    ,
    parameter int                 CNT_W     = 16
`endif
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [PC_W-1:0]    pc_in,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    pc_out
`ifdef IF_ID_STATS_EN
    ,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   bubble_cnt
`endif
);

    localparam int EW = INSTR_W + PC_W;

    if_id_state_e  state_q, state_d;
    logic          in_ready_q;
    logic          push, pop;
    logic          main_load, main_clr, skid_load, skid_clr;
    logic [EW-1:0] in_ent, main_d, main_q, skid_q;
    logic          main_vld, skid_vld;

    assign in_ent = {instr_in, pc_in};
    assign push   = in_valid & in_ready_q;
    assign pop    = main_vld & out_ready;

    always_comb begin
        state_d   = state_q;
        main_d    = in_ent;
        main_load = 1'b0;
        main_clr  = 1'b0;
        skid_load = 1'b0;
        skid_clr  = 1'b0;
        if (flush) begin
            state_d  = EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        main_load = 1'b1;
                        state_d   = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_load = 1'b1;
                    end else if (push) begin
                        skid_load = 1'b1;
                        state_d   = FULL;
                    end else if (pop) begin
                        main_clr  = 1'b1;
                        state_d   = EMPTY;
                    end
                end
                FULL: begin
                    // Skid entry is older than anything fetch can offer, so it moves up first.
                    if (pop) begin
                        main_d    = skid_q;
                        main_load = skid_vld;
                        main_clr  = !skid_vld;
                        skid_clr  = 1'b1;
                        state_d   = ONE;
                    end
                end
                default: begin
                    state_d  = EMPTY;
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    if_id_slot #(.W(EW)) u_main (
        .clock   (clock),
        .reset   (reset),
        .clear_i (main_clr),
        .load_i  (main_load),
        .d_i     (main_d),
        .vld_o   (main_vld),
        .q_o     (main_q)
    );

    if_id_slot #(.W(EW)) u_skid (
        .clock   (clock),
        .reset   (reset),
        .clear_i (skid_clr),
        .load_i  (skid_load),
        .d_i     (in_ent),
        .vld_o   (skid_vld),
        .q_o     (skid_q)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = main_vld;
    assign instr_out = main_vld ? main_q[EW-1:PC_W] : NOP_INSTR;
    assign pc_out    = main_vld ? main_q[PC_W-1:0]  : '0;

`ifdef IF_ID_STATS_EN
    logic [CNT_W-1:0] stall_q, bubble_q;

    // Saturating counters; only reset clears them, a flush leaves history intact.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (main_vld && !out_ready && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (!main_vld && (bubble_q != '1)) begin
                bubble_q <= bubble_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Directed bench for if_id_pipe_reg: stimulus queues expected entries, a negedge monitor checks every pop and bubble.
module tb_if_id_pipe_reg;
    import if_id_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr_in;
    logic [31:0] pc_in;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
`ifdef IF_ID_STATS_EN
    logic [1:0]  stall_cnt;
    logic [1:0]  bubble_cnt;
`endif

    if_id_entry_t exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    if_id_pipe_reg #(
        .INSTR_W   (32),
        .PC_W      (32),
        .NOP_INSTR (NOP)
`ifdef IF_ID_STATS_EN
        ,
        .CNT_W     (2)
`endif
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr_in  (instr_in),
        .pc_in     (pc_in),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr_out (instr_out),
        .pc_out    (pc_out)
`ifdef IF_ID_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input logic [31:0] i, input logic [31:0] p, input logic acc);
        in_valid = 1'b1;
        instr_in = i;
        pc_in    = p;
        check("in_ready_on_offer", 32'(in_ready), 32'(acc));
        if (acc) exp_q.push_back(if_id_entry_t'{instr: i, pc: p});
    endtask

    // Holds flush (and optionally reset) for one cycle; everything still queued is discarded after the monitor sampled it.
    task automatic flush_cycle(input logic with_reset);
        flush = 1'b1;
        reset = with_reset;
        @(negedge clock);
        #1;
        exp_q.delete();
        tick();
        flush    = 1'b0;
        reset    = 1'b0;
        in_valid = 1'b0;
    endtask

    always @(negedge clock) begin : monitor
        if_id_entry_t e;
        if (reset === 1'b0) begin
            if (out_valid) begin
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_out: got 0x%0h/0x%0h, expected no entry", instr_out, pc_out);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_instr", instr_out, e.instr);
                        check("out_pc", pc_out, e.pc);
                    end
                end
            end else begin
                check("bubble_instr", instr_out, NOP);
                check("bubble_pc", pc_out, 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr_in = '0; pc_in = '0;

        // Reset state
        tick(); tick();
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_in_ready",  32'(in_ready),  32'h1);
        check("rst_instr",     instr_out,      NOP);
        check("rst_pc",        pc_out,         32'h0);
        reset = 1'b0;

        // Pass-through, back-to-back
        out_ready = 1'b1;
        offer(32'd5, 32'd4, 1'b1);
        tick();
        check("lat_out_valid", 32'(out_valid), 32'h1);
        check("lat_instr",     instr_out,      32'd5);
        offer(32'd10, 32'd8, 1'b1);
        tick();
        check("b2b_out_valid", 32'(out_valid), 32'h1);
        check("b2b_instr",     instr_out,      32'd10);
        in_valid = 1'b0;
        tick();
        check("drain_out_valid", 32'(out_valid), 32'h0);

        // Stall fills main+skid; third offer refused until a pop frees a slot
        out_ready = 1'b0;
        offer(32'd5, 32'd4, 1'b1);
        tick();
        offer(32'd10, 32'd8, 1'b1);
        tick();
        offer(32'd15, 32'd12, 1'b0);
        tick();
        check("full_in_ready", 32'(in_ready), 32'h0);
        check("full_head_pc",  pc_out,        32'd4);
        out_ready = 1'b1;
        tick();
        offer(32'd15, 32'd12, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        check("skid_drained", 32'(out_valid), 32'h0);

        // Flush while FULL with fetch still offering
        out_ready = 1'b0;
        offer(32'd1, 32'd100, 1'b1);
        tick();
        offer(32'd2, 32'd104, 1'b1);
        tick();
        in_valid = 1'b1; instr_in = 32'd3; pc_in = 32'd108;
        flush_cycle(1'b0);
        check("flush_out_valid", 32'(out_valid), 32'h0);
        check("flush_instr",     instr_out,      NOP);
        check("flush_in_ready",  32'(in_ready),  32'h1);

        // Flush in ONE: pop in that cycle is consumed, the concurrent push is dropped
        offer(32'd7, 32'd200, 1'b1);
        tick();
        out_ready = 1'b1;
        in_valid = 1'b1; instr_in = 32'd8; pc_in = 32'd204;
        flush_cycle(1'b0);
        check("flush1_out_valid", 32'(out_valid), 32'h0);
        check("flush1_pc",        pc_out,         32'h0);
        tick(); tick();

        // Reset with flush while FULL
        out_ready = 1'b0;
        offer(32'd30, 32'd40, 1'b1);
        tick();
        offer(32'd31, 32'd44, 1'b1);
        tick();
        in_valid = 1'b0;
        flush_cycle(1'b1);
        check("rst2_out_valid", 32'(out_valid), 32'h0);
        check("rst2_in_ready",  32'(in_ready),  32'h1);
        check("rst2_instr",     instr_out,      NOP);
        check("rst2_pc",        pc_out,         32'h0);
        out_ready = 1'b1;
        offer(32'd20, 32'd16, 1'b1);
        tick();
        check("post_rst_valid", 32'(out_valid), 32'h1);
        check("post_rst_instr", instr_out,      32'd20);
        check("post_rst_pc",    pc_out,         32'd16);
        in_valid = 1'b0;
        tick();

`ifdef IF_ID_STATS_EN
        // Counters are 2 bits wide here, so 3 is the saturation point
        reset = 1'b1; out_ready = 1'b0;
        tick();
        check("cnt_rst_stall",  32'(stall_cnt),  32'h0);
        check("cnt_rst_bubble", 32'(bubble_cnt), 32'h0);
        reset = 1'b0;
        offer(32'd50, 32'd0, 1'b1);
        tick();
        in_valid = 1'b0;
        tick(); tick();
        check("stall_2",  32'(stall_cnt),  32'd2);
        check("bubble_1", 32'(bubble_cnt), 32'd1);
        tick();
        check("stall_3", 32'(stall_cnt), 32'd3);
        tick(); tick();
        check("stall_sat", 32'(stall_cnt), 32'd3);
        out_ready = 1'b1;
        tick();
        tick(); tick();
        check("bubble_3", 32'(bubble_cnt), 32'd3);
        tick();
        check("bubble_sat", 32'(bubble_cnt), 32'd3);
        flush_cycle(1'b0);
        check("flush_keeps_stall",  32'(stall_cnt),  32'd3);
        check("flush_keeps_bubble", 32'(bubble_cnt), 32'd3);
`endif

        tick();
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
